// File: rtl/src_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// src_mem_pkg
// Shared types and constants for the SRC memory bus arbiter.
//   arb_state_t : sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   PORT_CPU    : port index of the CPU memory controller (grant bit 0)
//   PORT_DBG    : port index of the debug/loader port (grant bit 1)
//   gnt_to_port : converts the one-hot grant vector into a port index
// -----------------------------------------------------------------------------
package src_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Grant bit positions equal port indices, so the DBG bit is the index.
    function automatic logic gnt_to_port(input logic [1:0] gnt);
        return gnt[PORT_DBG];
    endfunction

endpackage

// File: rtl/src_rr_arb2.sv
// -----------------------------------------------------------------------------
// src_rr_arb2
// Two-requester round-robin arbiter, purely combinational. The parent keeps
// the last-granted port and feeds it back in.
// Ports:
//   req_cpu  in  : CPU request
//   req_dbg  in  : debug/loader request
//   last_gnt in  : port index granted most recently
//   gnt      out : one-hot grant, bit PORT_CPU / bit PORT_DBG (0 when idle)
// -----------------------------------------------------------------------------
module src_rr_arb2
    import src_mem_pkg::*;
(
    input  logic       req_cpu,
    input  logic       req_dbg,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req_cpu && req_dbg) begin
            // Tie: the port that did not win last time goes now.
            if (last_gnt == PORT_DBG) begin
                gnt[PORT_CPU] = 1'b1;
            end else begin
                gnt[PORT_DBG] = 1'b1;
            end
        end else if (req_cpu) begin
            gnt[PORT_CPU] = 1'b1;
        end else if (req_dbg) begin
            gnt[PORT_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/src_mem_arbiter.sv
// -----------------------------------------------------------------------------
// src_mem_arbiter
// Shares the single SRC memory bus between the CPU memory controller and the
// debug/loader port. One access at a time, round-robin on contention; each
// access holds `enable` for ACCESS_CYCLES cycles, then a one-cycle DONE state
// pulses the winner's ack. Every output is a flop, so nothing combinational
// runs from a request input to the memory strobes.
// Parameters:
//   ADDR_W        : memory address width
//   DATA_W        : memory data width
//   ACCESS_CYCLES : cycles `enable` is held per access (>= 1)
// Ports:
//   clk, rst_n                    : clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata         : CPU request (level), write flag, addr, data
//   cpu_rdata, cpu_ack            : CPU read data register, completion pulse
//   dbg_req/we/addr/wdata         : debug port request, same meaning as CPU
//   dbg_rdata, dbg_ack            : debug read data register, completion pulse
//   address, read, enable         : memory address and strobes
//   mem_wdata, mem_drive          : write data and bus-drive enable for top
//   mem_rdata                     : data sampled from the memory bus
// -----------------------------------------------------------------------------
module src_mem_arbiter
    import src_mem_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,

    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              enable,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_drive,
    input  logic [DATA_W-1:0] mem_rdata
);

    // A one-cycle access still needs a 1-bit counter that stays at zero.
    localparam int               CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_last;
    logic              last_gnt_q;
    logic              gnt_port_q;

    logic [1:0]        gnt;
    logic              grant_fire;
    logic              sel_port;

    // Request captured at grant time; the access runs only from these.
    logic              lat_we_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;

    // Access attributes for the next cycle: the winning inputs on the grant
    // edge, the latched copy otherwise.
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    logic              enable_d;
    logic              read_d;
    logic              mem_drive_d;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              cpu_ack_d;
    logic              dbg_ack_d;
    logic              cpu_cap;
    logic              dbg_cap;

    src_rr_arb2 u_arb (
        .req_cpu  (cpu_req),
        .req_dbg  (dbg_req),
        .last_gnt (last_gnt_q),
        .gnt      (gnt)
    );

    assign cnt_last   = (cnt_q == CNT_LAST);
    assign grant_fire = (state_q == IDLE) && (|gnt);
    assign sel_port   = gnt_to_port(gnt);

    // ---- state register, access counter, grant bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_gnt_q <= PORT_DBG;
            gnt_port_q <= PORT_CPU;
        end else begin
            state_q <= state_d;
            if ((state_q == ACCESS) && !cnt_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (grant_fire) begin
                last_gnt_q <= sel_port;
                gnt_port_q <= sel_port;
            end
        end
    end

    // Latched request payload: only read while an access is in flight, so
    // it needs no reset.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            lat_we_q    <= acc_we;
            lat_addr_q  <= acc_addr;
            lat_wdata_q <= acc_wdata;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|gnt)    state_d = ACCESS;
            ACCESS:  if (cnt_last) state_d = DONE;
            DONE:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // ---- output logic (values registered on the next edge) ----
    always_comb begin
        acc_we    = lat_we_q;
        acc_addr  = lat_addr_q;
        acc_wdata = lat_wdata_q;
        if (state_q == IDLE) begin
            acc_we    = (sel_port == PORT_DBG) ? dbg_we    : cpu_we;
            acc_addr  = (sel_port == PORT_DBG) ? dbg_addr  : cpu_addr;
            acc_wdata = (sel_port == PORT_DBG) ? dbg_wdata : cpu_wdata;
        end

        enable_d    = (state_d == ACCESS);
        read_d      = enable_d && !acc_we;
        mem_drive_d = enable_d && acc_we;
        address_d   = enable_d    ? acc_addr  : '0;
        mem_wdata_d = mem_drive_d ? acc_wdata : '0;

        // The edge that ends the last ACCESS cycle both captures read data
        // and raises the ack, so rdata is valid in the ack cycle.
        cpu_ack_d = (state_q == ACCESS) && cnt_last && (gnt_port_q == PORT_CPU);
        dbg_ack_d = (state_q == ACCESS) && cnt_last && (gnt_port_q == PORT_DBG);
        cpu_cap   = cpu_ack_d && !lat_we_q;
        dbg_cap   = dbg_ack_d && !lat_we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= 1'b0;
            read      <= 1'b0;
            mem_drive <= 1'b0;
            address   <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            enable    <= enable_d;
            read      <= read_d;
            mem_drive <= mem_drive_d;
            address   <= address_d;
            mem_wdata <= mem_wdata_d;
            cpu_ack   <= cpu_ack_d;
            dbg_ack   <= dbg_ack_d;
            if (cpu_cap) begin
                cpu_rdata <= mem_rdata;
            end
            if (dbg_cap) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule
